// File: rtl/rect128_key_sched_pkg.sv
// Shared constants, state type and helpers for the RECTANGLE-128 key schedule.
package rect128_key_sched_pkg;

   localparam int ROW_W      = 32;
   localparam int RK_W       = 64;
   localparam int KS_NROUNDS = 25;
   localparam logic [4:0] KS_RC_INIT = 5'h01;

   localparam logic [3:0] RECT_SBOX [16] = '{
      4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
      4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } ks_state_e;

   function automatic logic [ROW_W-1:0] rotl(input logic [ROW_W-1:0] x, input int n);
      return (x << n) | (x >> (ROW_W - n));
   endfunction

endpackage

// File: rtl/rect128_key_sched_sbox4.sv
// Combinational 4-bit RECTANGLE S-box applied to one key-state column.
module rect_sbox4
   import rect128_key_sched_pkg::*;
(
   input  logic [3:0] x_i,
   output logic [3:0] y_o
);

   assign y_o = RECT_SBOX[x_i];

endmodule

// File: rtl/rect128_key_sched.sv
// Sequential RECTANGLE-128 key schedule emitting K0..K[NROUNDS] over a valid/ready handshake.
// Define RECT_KS_LASTKEY_EN to add ov_last_key, the 128-bit state that produced the final key.
module rect128_key_sched
   import rect128_key_sched_pkg::*;
#(
   parameter int         NROUNDS = KS_NROUNDS,
   parameter logic [4:0] RC_INIT = KS_RC_INIT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [ROW_W-1:0]  iv_key0,
   input  logic [ROW_W-1:0]  iv_key1,
   input  logic [ROW_W-1:0]  iv_key2,
   input  logic [ROW_W-1:0]  iv_key3,
   output logic              o_busy,
   output logic              o_rk_valid,
   input  logic              i_rk_ready,
   output logic [RK_W-1:0]   ov_rk,
   output logic [4:0]        ov_rk_idx,
   output logic              o_done
`ifdef RECT_KS_LASTKEY_EN
   ,
   output logic [4*ROW_W-1:0] ov_last_key
`endif
);

   localparam logic [4:0] LAST_IDX = 5'(NROUNDS);

   ks_state_e                state_q;
   logic [3:0][ROW_W-1:0]    rows_q;
   logic [3:0][ROW_W-1:0]    rows_d;
   logic [3:0][ROW_W-1:0]    sub_rows;
   logic [4:0]               rc_q;
   logic [4:0]               rc_d;
   logic [4:0]               idx_q;
   logic                     busy_q;
   logic                     valid_q;
   logic                     done_q;
   logic [7:0][3:0]          col_in;
   logic [7:0][3:0]          col_out;
`ifdef RECT_KS_LASTKEY_EN
   logic [4*ROW_W-1:0]       last_key_q;
`endif

   // Only the eight low columns pass through the S-box; bits 31:8 are untouched.
   for (genvar j = 0; j < 8; j++) begin : g_sbox
      assign col_in[j] = {rows_q[3][j], rows_q[2][j], rows_q[1][j], rows_q[0][j]};
      rect_sbox4 u_sbox (
         .x_i (col_in[j]),
         .y_o (col_out[j])
      );
   end

   always_comb begin
      // NOTE: sub_rows gets a full default before the per-bit overrides, so no latch is inferred.
      sub_rows = rows_q;
      for (int j = 0; j < 8; j++) begin
         for (int r = 0; r < 4; r++) begin
            sub_rows[r][j] = col_out[j][r];
         end
      end
      rows_d[0] = rotl(sub_rows[0], 8) ^ sub_rows[1];
      rows_d[1] = sub_rows[2];
      rows_d[2] = rotl(sub_rows[2], 16) ^ sub_rows[3];
      rows_d[3] = sub_rows[0];
      rows_d[0][4:0] = rows_d[0][4:0] ^ rc_q;
   end

   assign rc_d = {rc_q[3:0], rc_q[4] ^ rc_q[2]};

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      if (!rst_n) begin
         state_q    <= IDLE;
         rows_q     <= '0;
         rc_q       <= RC_INIT;
         idx_q      <= '0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
`ifdef RECT_KS_LASTKEY_EN
         last_key_q <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE, DONE: begin
               if (i_start) begin
                  state_q    <= RUN;
                  rows_q     <= {iv_key3, iv_key2, iv_key1, iv_key0};
                  rc_q       <= RC_INIT;
                  idx_q      <= '0;
                  busy_q     <= 1'b1;
                  valid_q    <= 1'b1;
`ifdef RECT_KS_LASTKEY_EN
                  last_key_q <= '0;
`endif
               end
            end
            RUN: begin
               if (i_rk_ready) begin
                  if (idx_q == LAST_IDX) begin
                     state_q    <= DONE;
                     busy_q     <= 1'b0;
                     valid_q    <= 1'b0;
                     done_q     <= 1'b1;
`ifdef RECT_KS_LASTKEY_EN
                     last_key_q <= rows_q;
`endif
                  end else begin
                     rows_q <= rows_d;
                     rc_q   <= rc_d;
                     idx_q  <= idx_q + 5'd1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_busy     = busy_q;
   assign o_rk_valid = valid_q;
   assign o_done     = done_q;
   assign ov_rk_idx  = idx_q;
   assign ov_rk      = {rows_q[3][15:0], rows_q[2][15:0], rows_q[1][15:0], rows_q[0][15:0]};
`ifdef RECT_KS_LASTKEY_EN
   assign ov_last_key = last_key_q;
`endif

endmodule

// File: tb/tb_rect128_key_sched.sv
// Self-checking bench for rect128_key_sched against a behavioural key-schedule model.
module tb_rect128_key_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic        i_rk_ready = 1'b0;
   logic [31:0] iv_key0 = '0;
   logic [31:0] iv_key1 = '0;
   logic [31:0] iv_key2 = '0;
   logic [31:0] iv_key3 = '0;
   logic        o_busy;
   logic        o_rk_valid;
   logic        o_done;
   logic [63:0] ov_rk;
   logic [4:0]  ov_rk_idx;
`ifdef RECT_KS_LASTKEY_EN
   logic [127:0] ov_last_key;
`endif

   int checks = 0;
   int failures = 0;

   logic [63:0]  exp_rk [26];
   logic [127:0] exp_last;

   localparam logic [3:0] SB [16] = '{
      4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
      4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2
   };
   localparam logic [4:0] RC_TAB [25] = '{
      5'h01, 5'h02, 5'h04, 5'h09, 5'h12, 5'h05, 5'h0B, 5'h16, 5'h0C, 5'h19,
      5'h13, 5'h07, 5'h0F, 5'h1F, 5'h1E, 5'h1C, 5'h18, 5'h11, 5'h03, 5'h06,
      5'h0D, 5'h1B, 5'h17, 5'h0E, 5'h1D
   };

   always #5 clk = ~clk;

   rect128_key_sched dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_start    (i_start),
      .iv_key0    (iv_key0),
      .iv_key1    (iv_key1),
      .iv_key2    (iv_key2),
      .iv_key3    (iv_key3),
      .o_busy     (o_busy),
      .o_rk_valid (o_rk_valid),
      .i_rk_ready (i_rk_ready),
      .ov_rk      (ov_rk),
      .ov_rk_idx  (ov_rk_idx),
      .o_done     (o_done)
`ifdef RECT_KS_LASTKEY_EN
      ,
      .ov_last_key(ov_last_key)
`endif
   );

   // Reference model: builds the full list of round keys for one master key.
   task automatic build_expected(input logic [31:0] k0, k1, k2, k3);
      logic [31:0] r [4];
      logic [31:0] s [4];
      logic [3:0]  sv;
      int          rc;
      int          col;
      r  = '{k0, k1, k2, k3};
      rc = 1;
      for (int i = 0; i <= 25; i++) begin
         exp_rk[i] = {r[3][15:0], r[2][15:0], r[1][15:0], r[0][15:0]};
         if (i < 25) begin
            s = r;
            for (int j = 0; j < 8; j++) begin
               col = int'({r[3][j], r[2][j], r[1][j], r[0][j]});
               sv  = SB[col];
               for (int b = 0; b < 4; b++) s[b][j] = sv[b];
            end
            r[0] = ((s[0] << 8) | (s[0] >> 24)) ^ s[1] ^ 32'(rc);
            r[1] = s[2];
            r[2] = ((s[2] << 16) | (s[2] >> 16)) ^ s[3];
            r[3] = s[0];
            rc   = ((rc << 1) & 31) | (((rc >> 4) ^ (rc >> 2)) & 1);
         end
      end
      exp_last = {r[3], r[2], r[1], r[0]};
   endtask

   // Called at a falling edge; returns at the next falling edge, where K0 should be visible.
   task automatic load_key(input logic [31:0] k0, k1, k2, k3);
      iv_key0 = k0;
      iv_key1 = k1;
      iv_key2 = k2;
      iv_key3 = k3;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      iv_key0 = $urandom();
      iv_key1 = $urandom();
      iv_key2 = $urandom();
      iv_key3 = $urandom();
   endtask

   // Consumes keys start_idx..25 against exp_rk, then checks the o_done cycle.
   task automatic run_sched(input string name, input int start_idx, input int ready_pct,
                            input int stall_idx, input int stall_len, input int poke_idx,
                            input bit chk_rc, input int exp_cycles);
      int exp_i   = start_idx;
      int cyc     = 0;
      int stalled = 0;
      bit poked   = 1'b0;
      bit rdy;
      while (exp_i <= 25 && cyc < 600) begin
         checks++;
         if (o_rk_valid !== 1'b1 || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL %s valid/busy at key %0d: got %b/%b want 1/1", name, exp_i, o_rk_valid, o_busy);
         end
         checks++;
         if (ov_rk_idx !== 5'(exp_i)) begin
            failures++;
            $display("FAIL %s idx: got %0d want %0d", name, ov_rk_idx, exp_i);
         end
         checks++;
         if (ov_rk !== exp_rk[exp_i]) begin
            failures++;
            $display("FAIL %s key %0d: got %h want %h", name, exp_i, ov_rk, exp_rk[exp_i]);
         end
         if (chk_rc && exp_i < 25) begin
            checks++;
            if (dut.rc_q !== RC_TAB[exp_i]) begin
               failures++;
               $display("FAIL %s rc before update %0d: got %h want %h", name, exp_i, dut.rc_q, RC_TAB[exp_i]);
            end
         end
         rdy = ($urandom_range(99) < ready_pct);
         if (exp_i == stall_idx && stalled < stall_len) begin
            rdy = 1'b0;
            stalled++;
         end
         if (exp_i == poke_idx && !poked) begin
            i_start = 1'b1;
            iv_key0 = $urandom();
            iv_key1 = $urandom();
            iv_key2 = $urandom();
            iv_key3 = $urandom();
            poked   = 1'b1;
         end
         i_rk_ready = rdy;
         @(negedge clk);
         i_start = 1'b0;
         cyc++;
         if (rdy) exp_i++;
      end
      if (cyc >= 600) begin
         failures++;
         $display("FAIL %s timeout: got %0d cycles want final handshake", name, cyc);
      end
      checks++;
      if (o_done !== 1'b1 || o_busy !== 1'b0 || o_rk_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s done/busy/valid: got %b/%b/%b want 1/0/0", name, o_done, o_busy, o_rk_valid);
      end
      if (exp_cycles >= 0) begin
         checks++;
         if (cyc !== exp_cycles) begin
            failures++;
            $display("FAIL %s cycle count: got %0d want %0d", name, cyc, exp_cycles);
         end
      end
`ifdef RECT_KS_LASTKEY_EN
      checks++;
      if (ov_last_key !== exp_last) begin
         failures++;
         $display("FAIL %s last key: got %h want %h", name, ov_last_key, exp_last);
      end
`endif
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      i_start = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (o_busy !== 1'b0 || o_rk_valid !== 1'b0 || o_done !== 1'b0) begin
         failures++;
         $display("FAIL reset flags: got busy=%b valid=%b done=%b want 0/0/0", o_busy, o_rk_valid, o_done);
      end
      checks++;
      if (ov_rk !== 64'h0 || ov_rk_idx !== 5'd0) begin
         failures++;
         $display("FAIL reset key/idx: got %h/%0d want 0/0", ov_rk, ov_rk_idx);
      end
      checks++;
      if (dut.rc_q !== 5'h01) begin
         failures++;
         $display("FAIL reset rc: got %h want 01", dut.rc_q);
      end
      i_start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (o_rk_valid !== 1'b0 || o_busy !== 1'b0) begin
         failures++;
         $display("FAIL idle after reset: got valid=%b busy=%b want 0/0", o_rk_valid, o_busy);
      end
   endtask

   task automatic test_zero_key();
      build_expected('0, '0, '0, '0);
      i_rk_ready = 1'b0;
      load_key('0, '0, '0, '0);
      checks++;
      if (o_rk_valid !== 1'b1 || ov_rk !== 64'h0 || ov_rk_idx !== 5'd0) begin
         failures++;
         $display("FAIL zero K0: got valid=%b key=%h idx=%0d want 1/0/0", o_rk_valid, ov_rk, ov_rk_idx);
      end
      i_rk_ready = 1'b1;
      @(negedge clk);
      i_rk_ready = 1'b0;
      // Hand-derived: rows r0=000000FE r1=000000FF r2=00FF0000 r3=0.
      checks++;
      if (ov_rk !== 64'h0000_0000_00FF_00FE || ov_rk_idx !== 5'd1) begin
         failures++;
         $display("FAIL zero K1: got %h idx %0d want 0000000000ff00fe idx 1", ov_rk, ov_rk_idx);
      end
      run_sched("zero_key", 1, 100, -1, 0, -1, 1'b0, -1);
   endtask

   task automatic test_back_to_back();
      build_expected('0, '0, '0, '0);
      load_key('0, '0, '0, '0);
      run_sched("back_to_back", 0, 100, -1, 0, -1, 1'b0, 26);
   endtask

   task automatic test_done_hold();
      for (int i = 0; i < 3; i++) begin
         i_rk_ready = 1'($urandom_range(1));
         @(negedge clk);
         checks++;
         if (o_done !== 1'b0 || o_rk_valid !== 1'b0 || o_busy !== 1'b0 || ov_rk_idx !== 5'd25) begin
            failures++;
            $display("FAIL done hold %0d: got done=%b valid=%b busy=%b idx=%0d want 0/0/0/25",
                     i, o_done, o_rk_valid, o_busy, ov_rk_idx);
         end
`ifdef RECT_KS_LASTKEY_EN
         checks++;
         if (ov_last_key !== exp_last) begin
            failures++;
            $display("FAIL done hold last key: got %h want %h", ov_last_key, exp_last);
         end
`endif
      end
   endtask

   task automatic test_rc_sequence();
      logic [31:0] k [4];
      for (int i = 0; i < 4; i++) k[i] = $urandom();
      build_expected(k[0], k[1], k[2], k[3]);
      load_key(k[0], k[1], k[2], k[3]);
      run_sched("rc_sequence", 0, 100, -1, 0, -1, 1'b1, 26);
   endtask

   task automatic test_backpressure();
      logic [31:0] k [4];
      for (int i = 0; i < 4; i++) k[i] = $urandom();
      build_expected(k[0], k[1], k[2], k[3]);
      load_key(k[0], k[1], k[2], k[3]);
      run_sched("backpressure", 0, 100, 5, 3, -1, 1'b0, 29);
   endtask

   task automatic test_start_ignored();
      logic [31:0] k [4];
      for (int i = 0; i < 4; i++) k[i] = $urandom();
      build_expected(k[0], k[1], k[2], k[3]);
      load_key(k[0], k[1], k[2], k[3]);
      run_sched("start_ignored", 0, 100, -1, 0, 10, 1'b0, 26);
   endtask

   task automatic test_reset_mid_run();
      logic [31:0] k [4];
      for (int i = 0; i < 4; i++) k[i] = $urandom();
      build_expected(k[0], k[1], k[2], k[3]);
      load_key(k[0], k[1], k[2], k[3]);
      i_rk_ready = 1'b1;
      for (int i = 0; i < 12; i++) @(negedge clk);
      checks++;
      if (ov_rk_idx !== 5'd12 || ov_rk !== exp_rk[12]) begin
         failures++;
         $display("FAIL reset_mid pre: got idx %0d key %h want 12 %h", ov_rk_idx, ov_rk, exp_rk[12]);
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (o_rk_valid !== 1'b0 || o_busy !== 1'b0 || ov_rk !== 64'h0 || ov_rk_idx !== 5'd0 || o_done !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid abort: got valid=%b busy=%b key=%h idx=%0d done=%b want 0/0/0/0/0",
                  o_rk_valid, o_busy, ov_rk, ov_rk_idx, o_done);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (o_rk_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid idle: got valid=%b want 0", o_rk_valid);
      end
      for (int i = 0; i < 4; i++) k[i] = $urandom();
      build_expected(k[0], k[1], k[2], k[3]);
      load_key(k[0], k[1], k[2], k[3]);
      run_sched("reset_mid_new_key", 0, 100, -1, 0, -1, 1'b0, 26);
   endtask

   task automatic test_random_ready();
      logic [31:0] k [4];
      for (int n = 0; n < 3; n++) begin
         for (int i = 0; i < 4; i++) k[i] = $urandom();
         build_expected(k[0], k[1], k[2], k[3]);
         load_key(k[0], k[1], k[2], k[3]);
         run_sched("random_ready", 0, 60, -1, 0, -1, 1'b1, -1);
      end
   endtask

   initial begin
      test_reset();
      test_zero_key();
      test_back_to_back();
      test_done_hold();
      test_rc_sequence();
      test_backpressure();
      test_start_ignored();
      test_reset_mid_run();
      test_random_ready();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
